// File: rtl/alu_mul_seq.sv
`timescale 1ns/1ps
// Unsigned shift-and-add multiplier that borrows the shared ALU for one ADD per multiplier bit.
// The product {prod_hi, prod_lo} is exact and is held until the next accepted start.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] prod_hi,
  output logic [W-1:0] prod_lo,
  output logic         alu_own,
  output logic [3:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout
);

  localparam int              CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [3:0]      ALU_ADD = 4'b0000;
  localparam logic [CW-1:0]   LAST    = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_mcand;
  logic [CW-1:0] r_cnt;
  logic          w_run;
  logic          w_accept;
  logic          w_zero;

  assign w_run    = (r_state == RUN);
  assign w_accept = start && !w_run;
  assign w_zero   = (op_a == '0) || (op_b == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = w_zero ? DONE : RUN;
      end
      RUN: begin
        if (r_cnt == LAST) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_accept) w_state_nxt = w_zero ? DONE : RUN;
        else          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Each RUN cycle adds the gated multiplicand and shifts {carry, sum, lo} right by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_acc   <= '0;
      r_lo    <= w_zero ? '0 : op_b;
      r_mcand <= op_a;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_acc   <= {alu_cout, alu_result[W-1:1]};
      r_lo    <= {alu_result[0], r_lo[W-1:1]};
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign busy     = w_run;
  assign alu_own  = w_run;
  assign done     = (r_state == DONE);
  assign prod_hi  = r_acc;
  assign prod_lo  = r_lo;
  assign alu_ctrl = ALU_ADD;
  assign alu_a    = w_run ? r_acc : '0;
  assign alu_b    = (w_run && r_lo[0]) ? r_mcand : '0;

endmodule

// File: tb/tb_alu_mul_seq.sv
`timescale 1ns/1ps
// Bench for alu_mul_seq: a simple ADD-only ALU model closes the loop, and results are
// compared against plain integer multiplication and the documented latency.
module tb_alu_mul_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] prod_hi;
  logic [W-1:0] prod_lo;
  logic         alu_own;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_cout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign {alu_cout, alu_result} = (alu_ctrl == 4'b0000) ?
                                  ({1'b0, alu_a} + {1'b0, alu_b}) : '0;

  alu_mul_seq #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .prod_hi    (prod_hi),
    .prod_lo    (prod_lo),
    .alu_own    (alu_own),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    return ((a == 0) || (b == 0)) ? 1 : W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle 1 after the start cycle.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Returns cycles since the start cycle at which done was seen (40 on timeout)
  // and the number of cycles alu_own was high before that.
  task automatic wait_done(output int lat, output int own);
    lat = 1;
    own = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (alu_own === 1'b1) own++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, alu_own} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl: busy/done/own=%b required 000", {busy, done, alu_own});
    end
    n_checks++;
    if ({prod_hi, prod_lo} !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_prod: got %h required 0000", {prod_hi, prod_lo});
    end
    n_checks++;
    if ({alu_ctrl, alu_a, alu_b} !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_alu: ctrl=%h a=%h b=%h required all 0", alu_ctrl, alu_a, alu_b);
    end
  endtask

  task automatic test_basic();
    int lat;
    int own;
    do_start(8'd13, 8'd11);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if ({busy, alu_own, done} !== 3'b110) begin
        n_errors++;
        $display("FAIL basic_run_c%0d: busy/own/done=%b required 110", c, {busy, alu_own, done});
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== 16'h008F) begin
      n_errors++;
      $display("FAIL basic_done: done=%b prod=%h required 1 008f", done, {prod_hi, prod_lo});
    end
    tick();
    op_a = 8'hAA;
    op_b = 8'h55;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {prod_hi, prod_lo} !== 16'h008F) begin
        n_errors++;
        $display("FAIL basic_hold: done=%b busy=%b prod=%h required 0 0 008f",
                 done, busy, {prod_hi, prod_lo});
      end
      tick();
    end
    do_start(8'd255, 8'd255);
    wait_done(lat, own);
    n_checks++;
    if (lat != 9 || own != 8 || {prod_hi, prod_lo} !== 16'hFE01) begin
      n_errors++;
      $display("FAIL max_operands: lat=%0d own=%0d prod=%h required 9 8 fe01",
               lat, own, {prod_hi, prod_lo});
    end
    tick();
  endtask

  task automatic test_early_exit();
    logic [W-1:0] as [2];
    logic [W-1:0] bs [2];
    as[0] = 8'd0;   bs[0] = 8'd200;
    as[1] = 8'd200; bs[1] = 8'd0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({prod_hi, prod_lo} === 16'h0000 && k == 0) begin
        n_errors++;
        $display("FAIL early_precond: prod=%h required nonzero from previous op", {prod_hi, prod_lo});
      end
      do_start(as[k], bs[k]);
      n_checks++;
      if (done !== 1'b1 || alu_own !== 1'b0 || busy !== 1'b0 || {prod_hi, prod_lo} !== 16'h0000) begin
        n_errors++;
        $display("FAIL early_exit_%0d: done=%b own=%b busy=%b prod=%h required 1 0 0 0000",
                 k, done, alu_own, busy, {prod_hi, prod_lo});
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || alu_own !== 1'b0) begin
        n_errors++;
        $display("FAIL early_after_%0d: done=%b own=%b required 0 0", k, done, alu_own);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int own;
    do_start(8'd6, 8'd7);
    tick();
    start = 1'b1;
    op_a  = 8'd9;
    op_b  = 8'd9;
    for (int c = 2; c <= 8; c++) begin
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL ignore_run_c%0d: done=%b busy=%b required 0 1", c, done, busy);
      end
      tick();
    end
    n_checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== 16'h002A) begin
      n_errors++;
      $display("FAIL ignore_first: done=%b prod=%h required 1 002a", done, {prod_hi, prod_lo});
    end
    tick();
    start = 1'b0;
    wait_done(lat, own);
    n_checks++;
    if (lat != 9 || {prod_hi, prod_lo} !== 16'h0051) begin
      n_errors++;
      $display("FAIL ignore_second: lat=%0d prod=%h required 9 0051", lat, {prod_hi, prod_lo});
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    int own;
    int pulses;
    do_start(8'd200, 8'd3);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy, alu_own, done} !== 3'b000 || {prod_hi, prod_lo} !== 16'h0000) begin
      n_errors++;
      $display("FAIL abort_state: busy/own/done=%b prod=%h required 000 0000",
               {busy, alu_own, done}, {prod_hi, prod_lo});
    end
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL abort_no_done: pulses=%0d required 0", pulses);
    end
    do_start(8'd3, 8'd7);
    wait_done(lat, own);
    n_checks++;
    if (lat != 9 || {prod_hi, prod_lo} !== 16'h0015) begin
      n_errors++;
      $display("FAIL abort_restart: lat=%0d prod=%h required 9 0015", lat, {prod_hi, prod_lo});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    op_a  = 8'd5;
    op_b  = 8'd5;
    tick();
    op_a = 8'd16;
    op_b = 8'd16;
    for (int c = 1; c <= 18; c++) begin
      n_checks++;
      if (done !== ((c == 9) || (c == 18))) begin
        n_errors++;
        $display("FAIL b2b_done_c%0d: done=%b required %b", c, done, (c == 9) || (c == 18));
      end
      if (c == 9) begin
        n_checks++;
        if ({prod_hi, prod_lo} !== 16'h0019) begin
          n_errors++;
          $display("FAIL b2b_first: prod=%h required 0019", {prod_hi, prod_lo});
        end
      end
      if (c == 18) begin
        n_checks++;
        if ({prod_hi, prod_lo} !== 16'h0100) begin
          n_errors++;
          $display("FAIL b2b_second: prod=%h required 0100", {prod_hi, prod_lo});
        end
        start = 1'b0;
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int lat;
    int own;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) a = '0;
      if ($urandom_range(0, 5) == 0) b = '0;
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      do_start(a, b);
      wait_done(lat, own);
      n_checks++;
      if (lat != ref_lat(a, b) || own != ref_lat(a, b) - 1 ||
          {prod_hi, prod_lo} !== ref_prod(a, b)) begin
        n_errors++;
        $display("FAIL rand_%0d %0d*%0d: lat=%0d own=%0d prod=%h required %0d %0d %h",
                 i, a, b, lat, own, {prod_hi, prod_lo},
                 ref_lat(a, b), ref_lat(a, b) - 1, ref_prod(a, b));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_exit();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle unsigned multiply sequencer that borrows the shared ALU to run shift-and-add multiplication. It drives ALU_ADD from the ALU_DEF ALU_CTRL encoding once per iteration and shifts the partial product internally. It sits beside the core datapath. While it owns the ALU (alu_own=1), the core stalls and the ALU operand/control muxes select this block.

Parameters:
W, 8, operand width in bits; ALU data width; product is 2W bits.
CW, $clog2(W), iteration counter width (derived; not overridden).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a multiply; sampled only when not busy
op_a  in  W  multiplicand, captured on accepted start
op_b  in  W  multiplier, captured on accepted start
busy  out  1  high while state=RUN
done  out  1  one-cycle pulse; product valid
prod_hi  out  W  upper half of product
prod_lo  out  W  lower half of product
alu_own  out  1  high while this block drives the ALU (state=RUN)
alu_ctrl  out  4  ALU_CTRL code; ALU_ADD (4'b0000) at all times
alu_a  out  W  ALU operand A
alu_b  out  W  ALU operand B
alu_result  in  W  ALU result, combinational, same cycle
alu_cout  in  1  carry out of ALU_ADD, same cycle

Behaviour:
- States: IDLE, RUN, DONE.
- Registers: acc (W), lo (W), mcand (W), cnt (CW).
- Reset:
  - state=IDLE; acc, lo, mcand, cnt=0.
  - busy=0, done=0, alu_own=0, alu_a=0, alu_b=0, alu_ctrl=ALU_ADD.
  - Reset in any state, including mid-RUN, aborts the operation. No done is issued.
- Accept:
  - start=1 in IDLE or DONE is accepted.
  - start is ignored in RUN and has no effect on the operation in flight.
- On accept, when op_a=0 or op_b=0 (early exit):
  - acc=0, lo=0, go to DONE.
  - ALU is never claimed. Latency is 1 cycle: done is high in the cycle after start.
- On accept, otherwise:
  - acc=0, lo=op_b, mcand=op_a, cnt=0, go to RUN.
- RUN, each cycle:
  - alu_a=acc.
  - alu_b = lo[0] ? mcand : 0.
  - Update: acc <= {alu_cout, alu_result[W-1:1]}; lo <= {alu_result[0], lo[W-1:1]}; cnt <= cnt+1.
  - When cnt=W-1, go to DONE.
  - Exactly W RUN cycles; done is asserted W+1 cycles after the start edge.
- DONE:
  - done=1 for exactly one cycle.
  - Returns to IDLE, or to RUN/DONE on a new accepted start (back-to-back, no bubble).
- Outputs:
  - prod_hi=acc, prod_lo=lo, driven directly from registers.
  - Valid in DONE and held unchanged in IDLE until the next accepted start.
  - Contents during RUN are don't-care.
- ALU drive outside RUN: alu_a=0, alu_b=0, alu_ctrl=ALU_ADD.
- alu_own and busy are decoded from state only (glitch-free, registered state).
- Arithmetic: unsigned; the full 2W-bit product is always exact, so no overflow flag is needed.

Test Plan:
1. W=8, op_a=13, op_b=11, start pulsed at cycle 0 -> busy=1 and alu_own=1 for cycles 1-8; done=1 at cycle 9 only; prod_hi=0x00, prod_lo=0x8F (143).
2. op_a=255, op_b=255 -> done at cycle 9; prod_hi=0xFE, prod_lo=0x01 (65025). Checks the carry path on every iteration.
3. op_a=0, op_b=200 -> done at cycle 1; alu_own never asserted; prod={0x00,0x00}. Repeat with op_a=200, op_b=0 -> same result.
4. Start 6x7, then hold start=1 with op_a=9, op_b=9 during cycles 2-8 of RUN -> done at cycle 9 with prod_lo=42 (0x2A), prod_hi=0. The second request is only taken at the done cycle, giving 81 (0x51) 9 cycles later.
5. Start 200x3, assert reset in RUN cycle 4 -> next cycle: busy=0, alu_own=0, prod=0, no done pulse. Then start 3x7 -> done 9 cycles later with prod_lo=21 (0x15).
6. Back-to-back: start held every cycle with 5x5 then 16x16 -> done pulses at cycles 9 and 18; products 25 (0x0019), then 256 (prod_hi=0x01, prod_lo=0x00).
